dm_cache_ctrl: RTL and testbench
================================

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address width.
REQ-002 SHALL have parameter C, default 128, capacity in bytes.
REQ-003 SHALL have parameter B, default 4, line size in bytes; one line is one data word of B*8 bits.
REQ-004 SHALL have parameter S, default C/B, number of sets.
REQ-005 Ports; one clock; reset is asynchronous and active-low:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_v_i  in  1  request valid.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  WIDTH  byte address.
- cpu_data_i  in  B*8  write data.
- cpu_ready_o  out  1  request may be accepted.
- cpu_v_o  out  1  response valid, one-cycle pulse.
- cpu_hit_o  out  1  original lookup hit; valid with cpu_v_o.
- cpu_data_o  out  B*8  read data; valid with cpu_v_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = writeback, 0 = fill.
- mem_addr_o  out  WIDTH  line-aligned address.
- mem_data_o  out  B*8  writeback data.
- mem_ack_i  in  1  memory done; fill data valid this cycle.
- mem_data_i  in  B*8  fill data.

Function
REQ-006 SHALL hold per-set valid, dirty, tag and data arrays, addressed as follows:
- offset = addr[clog2(B)-1:0].
- index = next clog2(S) bits.
- tag = remaining upper bits.
REQ-007 SHALL implement FSM states IDLE, CMP, WB, FILL, RESP.
REQ-008 IDLE SHALL:
- drive cpu_ready_o=1 only in this state;
- accept a request on the edge where cpu_v_i=1, latching addr, we and data;
- go to CMP.
REQ-009 CMP SHALL branch:
- hit (valid and tag equal) -> RESP;
- miss with victim valid and dirty -> WB;
- read miss, victim clean or invalid -> FILL;
- write miss, victim clean or invalid -> RESP.
REQ-010 WB SHALL:
- drive mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, zero offset}, mem_data_o=victim data;
- on the mem_ack_i cycle, go to FILL (read) or RESP (write).
REQ-011 FILL SHALL:
- drive mem_req_o=1, mem_we_o=0, mem_addr_o={request tag, index, zero offset};
- on mem_ack_i, install mem_data_i as valid and clean, then go to RESP.
REQ-012 RESP SHALL:
- assert cpu_v_o for exactly one cycle, then return to IDLE;
- for a read, put the line data on cpu_data_o;
- for a write, write the latched data into the line with valid=1, dirty=1 and the request tag.
REQ-013 A write miss SHALL never issue a fill, since the full line is overwritten.
REQ-014 Hit latency SHALL be two cycles: accept edge N, cpu_v_o high in the cycle after edge N+1.
REQ-015 mem_req_o, mem_we_o, mem_addr_o and mem_data_o SHALL stay stable from assertion through the cycle mem_ack_i is sampled high, and mem_req_o SHALL deassert in the next cycle.
REQ-016 mem_ack_i SHALL be ignored while mem_req_o=0.
REQ-017 cpu_v_i while cpu_ready_o=0 SHALL be ignored, not queued.
REQ-018 cpu_hit_o SHALL reflect the CMP-cycle result, not the post-fill state.

Reset
REQ-019 rst_n=0 SHALL immediately put the FSM in IDLE and clear all valid and dirty bits; dirty data is discarded.
REQ-020 During reset, outputs SHALL be:
- cpu_ready_o=1;
- cpu_v_o, cpu_hit_o, mem_req_o, mem_we_o = 0;
- cpu_data_o, mem_addr_o, mem_data_o = 0.
REQ-021 Reset mid-transaction SHALL drop mem_req_o asynchronously, and no response SHALL be issued for the aborted request.

Configuration
REQ-022 With DM_CACHE_CTRL_STATS_EN defined, the block SHALL add outputs hit_cnt_o and miss_cnt_o, each 16 bits:
- each increments in RESP per hit or miss;
- each saturates at 0xFFFF;
- each resets to 0.
REQ-023 Without DM_CACHE_CTRL_STATS_EN, these ports and counters SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-024 After reset, read 0x40 with fill data 0xDEADBEEF:
- mem_req_o with mem_we_o=0, mem_addr_o=0x40;
- cpu_data_o=0xDEADBEEF, cpu_hit_o=0.
Re-read 0x40 -> cpu_hit_o=1, no mem_req_o, cpu_v_o two cycles after accept.
REQ-025 Write 0x40 with 0x11111111 (hit), then read 0xC0 (same index 16, tag 1):
- WB with mem_addr_o=0x40, mem_data_o=0x11111111;
- then FILL with mem_addr_o=0xC0.
REQ-026 Write miss to invalid 0x80 with 0x22222222 -> no mem_req_o, cpu_hit_o=0. Read 0x80 -> hit, data 0x22222222.
REQ-027 Delay mem_ack_i 5 cycles during FILL -> mem_req_o, mem_addr_o stable all 5 cycles, cpu_ready_o=0 throughout.
REQ-028 Assert rst_n=0 mid-WB:
- mem_req_o=0 same cycle;
- after release cpu_ready_o=1;
- read 0x40 misses.
REQ-029 With DM_CACHE_CTRL_STATS_EN, REQ-024 sequence -> hit_cnt_o=1, miss_cnt_o=1.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller (one word per line).
// Define DM_CACHE_CTRL_STATS_EN to add saturating hit/miss counter outputs.
module dm_cache_ctrl #(
    parameter int WIDTH = 32,
    parameter int C     = 128,
    parameter int B     = 4,
    parameter int S     = C / B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_v_i,
    input  logic             cpu_we_i,
    input  logic [WIDTH-1:0] cpu_addr_i,
    input  logic [B*8-1:0]   cpu_data_i,
    output logic             cpu_ready_o,
    output logic             cpu_v_o,
    output logic             cpu_hit_o,
    output logic [B*8-1:0]   cpu_data_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [B*8-1:0]   mem_data_o,
    input  logic             mem_ack_i,
    input  logic [B*8-1:0]   mem_data_i
`ifdef DM_CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]      hit_cnt_o,
    output logic [15:0]      miss_cnt_o
`endif
);

    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(S);
    localparam int TAG_W = WIDTH - IDX_W - OFF_W;
    localparam int DW    = B * 8;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        WB,
        FILL,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req_we;
    logic [DW-1:0]    req_data;
    logic             hit_q;

    logic [S-1:0]     valid_q;
    logic [S-1:0]     dirty_q;
    logic [TAG_W-1:0] tag_q  [S];
    logic [DW-1:0]    data_q [S];

    logic [TAG_W-1:0] cur_tag;
    logic [DW-1:0]    cur_data;
    logic             cur_valid;
    logic             cur_dirty;
    logic             hit;
    logic             accept;
    logic             fill_done;
    logic             wr_done;
    logic             unused_off;

    // Byte offset is irrelevant: a line holds exactly one word.
    assign unused_off = ^cpu_addr_i[OFF_W-1:0];

    assign cur_tag   = tag_q[req_idx];
    assign cur_data  = data_q[req_idx];
    assign cur_valid = valid_q[req_idx];
    assign cur_dirty = dirty_q[req_idx];
    assign hit       = cur_valid && (cur_tag == req_tag);

    assign accept    = (state_q == IDLE) && cpu_v_i;
    assign fill_done = (state_q == FILL) && mem_ack_i;
    assign wr_done   = (state_q == RESP) && req_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_ready_o = 1'b0;
        cpu_v_o     = 1'b0;
        cpu_hit_o   = 1'b0;
        cpu_data_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        unique case (state_q)
            IDLE: begin
                cpu_ready_o = 1'b1;
                if (cpu_v_i) state_d = CMP;
            end
            CMP: begin
                if (hit) begin
                    state_d = RESP;
                end else if (cur_valid && cur_dirty) begin
                    state_d = WB;
                end else if (!req_we) begin
                    state_d = FILL;
                end else begin
                    state_d = RESP;
                end
            end
            WB: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {cur_tag, req_idx, {OFF_W{1'b0}}};
                mem_data_o = cur_data;
                if (mem_ack_i) state_d = req_we ? RESP : FILL;
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_ack_i) state_d = RESP;
            end
            RESP: begin
                cpu_v_o    = 1'b1;
                cpu_hit_o  = hit_q;
                cpu_data_o = req_we ? '0 : cur_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_tag  <= '0;
            req_idx  <= '0;
            req_we   <= 1'b0;
            req_data <= '0;
            hit_q    <= 1'b0;
        end else begin
            if (accept) begin
                req_tag  <= cpu_addr_i[WIDTH-1 -: TAG_W];
                req_idx  <= cpu_addr_i[OFF_W +: IDX_W];
                req_we   <= cpu_we_i;
                req_data <= cpu_data_i;
            end
            // Hit flag is frozen at lookup time, before any fill.
            if (state_q == CMP) hit_q <= hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
        end else if (wr_done) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_data_i;
        end else if (wr_done) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= req_data;
        end
    end

`ifdef DM_CACHE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == RESP) begin
            if (hit_q) begin
                if (hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
            end else begin
                if (miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios then random traffic
// against a line-level cache and backing-memory model.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_v_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_ready_o;
    logic        cpu_v_o;
    logic        cpu_hit_o;
    logic [31:0] cpu_data_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
`ifdef DM_CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    bit          m_valid [32];
    bit          m_dirty [32];
    logic [31:0] m_tag   [32];
    logic [31:0] m_data  [32];
    logic [31:0] mem_model [logic [31:0]];
    int          m_hits = 0;
    int          m_miss = 0;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_v_i    (cpu_v_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_ready_o(cpu_ready_o),
        .cpu_v_o    (cpu_v_o),
        .cpu_hit_o  (cpu_hit_o),
        .cpu_data_o (cpu_data_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i)
`ifdef DM_CACHE_CTRL_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_valid[k] = 0;
            m_dirty[k] = 0;
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic check_reset_outs();
        check("rst_ready", {31'd0, cpu_ready_o}, 32'd1);
        check("rst_v", {31'd0, cpu_v_o}, 32'd0);
        check("rst_hit", {31'd0, cpu_hit_o}, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_mwe", {31'd0, mem_we_o}, 32'd0);
        check("rst_cdata", cpu_data_o, 32'd0);
        check("rst_maddr", mem_addr_o, 32'd0);
        check("rst_mdata", mem_data_o, 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly,
                          output logic o_hit, output logic [31:0] o_data,
                          output int o_mem);
        int          idx;
        logic [31:0] tg;
        bit          ehit;
        bit          ewb;
        bit          efill;
        int          nph;
        int          exp_lat;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
        logic [31:0] fl_addr;
        logic [31:0] fl_data;
        logic [31:0] exp_data;
        int          p = 0;
        int          held = 0;
        bit          done = 0;
        bit          is_wb;

        idx     = int'((addr / 4) % 32);
        tg      = addr / 128;
        ehit    = m_valid[idx] && (m_tag[idx] == tg);
        ewb     = !ehit && m_valid[idx] && m_dirty[idx];
        efill   = !ehit && !we;
        nph     = int'(ewb) + int'(efill);
        exp_lat = 1 + nph * (dly + 1);
        wb_addr = m_tag[idx] * 128 + idx * 4;
        wb_data = m_data[idx];
        fl_addr = addr - (addr % 4);
        if (!mem_model.exists(fl_addr)) mem_model[fl_addr] = $urandom;
        fl_data  = mem_model[fl_addr];
        exp_data = ehit ? m_data[idx] : fl_data;
        o_hit  = 0;
        o_data = 0;
        o_mem  = 0;

        check("idle_ready", {31'd0, cpu_ready_o}, 32'd1);
        check("idle_v", {31'd0, cpu_v_o}, 32'd0);
        cpu_v_i    = 1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        mem_ack_i  = 0;
        @(negedge clk);
        for (int i = 0; i < 80 && !done; i++) begin
            check("busy_ready", {31'd0, cpu_ready_o}, 32'd0);
            if (mem_req_o) begin
                o_mem++;
                if (p >= nph) begin
                    check("mem_extra", {31'd0, mem_req_o}, 32'd0);
                    mem_ack_i = 1;
                end else begin
                    is_wb = ewb && (p == 0);
                    check("mem_we", {31'd0, mem_we_o}, {31'd0, is_wb});
                    check("mem_addr", mem_addr_o, is_wb ? wb_addr : fl_addr);
                    if (is_wb) check("mem_wdata", mem_data_o, wb_data);
                    if (held == dly) begin
                        mem_ack_i  = 1;
                        mem_data_i = is_wb ? $urandom : fl_data;
                        p++;
                        held = 0;
                    end else begin
                        mem_ack_i = 0;
                        held++;
                    end
                end
            end else begin
                mem_ack_i  = ($urandom_range(0, 3) == 0);
                mem_data_i = $urandom;
            end
            if (cpu_v_o) begin
                check("lat", i, exp_lat);
                check("hit", {31'd0, cpu_hit_o}, {31'd0, ehit});
                if (!we) check("rdata", cpu_data_o, exp_data);
                o_hit     = cpu_hit_o;
                o_data    = cpu_data_o;
                done      = 1;
                cpu_v_i   = 0;
                mem_ack_i = 0;
            end else begin
                cpu_v_i    = $urandom_range(0, 1);
                cpu_we_i   = $urandom_range(0, 1);
                cpu_addr_i = $urandom;
                cpu_data_i = $urandom;
            end
            @(negedge clk);
        end
        if (!done) begin
            check("resp_timeout", 32'd0, 32'd1);
            cpu_v_i   = 0;
            mem_ack_i = 0;
        end
        check("mem_phases", p, nph);

        if (ewb) mem_model[wb_addr] = wb_data;
        if (efill) begin
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = tg;
            m_data[idx]  = fl_data;
        end
        if (we) begin
            m_valid[idx] = 1;
            m_dirty[idx] = 1;
            m_tag[idx]   = tg;
            m_data[idx]  = wdata;
        end
        if (ehit) m_hits++;
        else m_miss++;
    endtask

    logic        r_hit;
    logic [31:0] r_data;
    int          r_mem;

    initial begin
        rst_n      = 0;
        cpu_v_i    = 0;
        cpu_we_i   = 0;
        cpu_addr_i = 0;
        cpu_data_i = 0;
        mem_ack_i  = 0;
        mem_data_i = 0;
        model_reset();
        #12;
        check_reset_outs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        mem_model[32'h40] = 32'hDEADBEEF;
        do_req(0, 32'h40, 0, 0, r_hit, r_data, r_mem);
        check("t24_hit", {31'd0, r_hit}, 32'd0);
        check("t24_data", r_data, 32'hDEADBEEF);
        check("t24_mem", r_mem, 1);
        do_req(0, 32'h40, 0, 0, r_hit, r_data, r_mem);
        check("t24b_hit", {31'd0, r_hit}, 32'd1);
        check("t24b_mem", r_mem, 0);
`ifdef DM_CACHE_CTRL_STATS_EN
        check("t29_hits", {16'd0, hit_cnt_o}, 32'd1);
        check("t29_miss", {16'd0, miss_cnt_o}, 32'd1);
`endif

        do_req(1, 32'h40, 32'h11111111, 0, r_hit, r_data, r_mem);
        check("t25w_hit", {31'd0, r_hit}, 32'd1);
        do_req(0, 32'hC0, 0, 1, r_hit, r_data, r_mem);
        check("t25_hit", {31'd0, r_hit}, 32'd0);
        check("t25_mem", r_mem, 4);
        check("t25_wbmem", mem_model[32'h40], 32'h11111111);

        do_req(1, 32'h80, 32'h22222222, 0, r_hit, r_data, r_mem);
        check("t26w_hit", {31'd0, r_hit}, 32'd0);
        check("t26w_mem", r_mem, 0);
        do_req(0, 32'h80, 0, 0, r_hit, r_data, r_mem);
        check("t26_hit", {31'd0, r_hit}, 32'd1);
        check("t26_data", r_data, 32'h22222222);

        do_req(0, 32'h1C0, 0, 5, r_hit, r_data, r_mem);
        check("t27_hit", {31'd0, r_hit}, 32'd0);
        check("t27_mem", r_mem, 6);

        do_req(1, 32'h40, 32'h33333333, 0, r_hit, r_data, r_mem);
        cpu_v_i    = 1;
        cpu_we_i   = 0;
        cpu_addr_i = 32'hC0;
        @(negedge clk);
        cpu_v_i = 0;
        @(negedge clk);
        check("t28_inwb", {31'd0, mem_req_o}, 32'd1);
        check("t28_inwb_we", {31'd0, mem_we_o}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        check_reset_outs();
        @(negedge clk);
        check_reset_outs();
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(negedge clk);
        check("t28_ready", {31'd0, cpu_ready_o}, 32'd1);
        check("t28_nov", {31'd0, cpu_v_o}, 32'd0);
        do_req(0, 32'h40, 0, 0, r_hit, r_data, r_mem);
        check("t28_miss", {31'd0, r_hit}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom_range(0, 3) * 128 + $urandom_range(0, 31) * 4
              + $urandom_range(0, 3);
            do_req(1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 3), r_hit, r_data, r_mem);
        end
`ifdef DM_CACHE_CTRL_STATS_EN
        check("end_hits", {16'd0, hit_cnt_o}, m_hits);
        check("end_miss", {16'd0, miss_cnt_o}, m_miss);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
